// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider (seq_div).
// Build option: DIV_SIGNED_EN selects two's-complement operands.
package div_pkg;

  localparam int unsigned DivDW = 16;
  localparam int unsigned DivVW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Iteration counter must be able to hold the value DW.
  function automatic int unsigned count_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned DivCntW = $clog2(DivDW + 1);

  // Results presented on divide-by-zero.
  localparam logic [DivDW-1:0] DzQuot = '1;
  localparam logic [DivVW-1:0] DzRem  = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, conditionally subtract.
// Purely combinational; instantiated once by seq_div.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned VW = DivVW
) (
  input  logic [VW:0]   p,
  input  logic          bit_in,
  input  logic [VW-1:0] b,
  output logic [VW:0]   p_next,
  output logic          q_bit
);

  logic [VW:0] shifted;
  logic [VW:0] b_ext;
  logic [VW:0] diff;

  always_comb begin
    shifted = {p[VW-1:0], bit_in};
    b_ext   = {1'b0, b};
    // A set top bit in p means the shifted value exceeds VW+1 bits, so it is >= b.
    q_bit   = p[VW] || (shifted >= b_ext);
    diff    = shifted - b_ext;
    p_next  = q_bit ? diff : shifted;
  end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Build option: DIV_SIGNED_EN (two's-complement operands, quotient truncates toward zero).
module seq_div
  import div_pkg::*;
#(
  parameter int unsigned DW = DivDW,
  parameter int unsigned VW = DivVW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] A,
  input  logic [VW-1:0] B,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          dz
);

  localparam int unsigned CntW = count_width(DW);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Dividend shifts out of the top while quotient bits shift in at the bottom.
  logic [DW-1:0]   a_q, a_d;
  logic [VW:0]     p_q, p_d;
  logic [VW-1:0]   b_q, b_d;
  logic            dzp_q, dzp_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DW-1:0]   q_q, q_d;
  logic [VW-1:0]   r_q, r_d;
  logic            dz_q, dz_d;

`ifdef DIV_SIGNED_EN
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
`endif

  logic [VW:0]     step_p;
  logic            step_q;
  logic [DW-1:0]   q_fin;
  logic [VW-1:0]   r_fin;

  div_step #(
    .VW(VW)
  ) u_step (
    .p     (p_q),
    .bit_in(a_q[DW-1]),
    .b     (b_q),
    .p_next(step_p),
    .q_bit (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    p_d     = p_q;
    b_d     = b_q;
    dzp_d   = dzp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    q_fin   = qneg_q ? -a_q : a_q;
    r_fin   = rneg_q ? -p_q[VW-1:0] : p_q[VW-1:0];
`else
    q_fin   = a_q;
    r_fin   = p_q[VW-1:0];
`endif

    // busy drops the edge after the done pulse unless a new start is accepted then.
    if (done_q) begin
      busy_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          p_d    = '0;
          dzp_d  = (B == '0);
`ifdef DIV_SIGNED_EN
          a_d    = A[DW-1] ? -A : A;
          b_d    = B[VW-1] ? -B : B;
          qneg_d = A[DW-1] ^ B[VW-1];
          rneg_d = A[DW-1];
`else
          a_d    = A;
          b_d    = B;
`endif
          state_d = (B == '0) ? StDone : StRun;
        end
      end

      StRun: begin
        p_d   = step_p;
        a_d   = {a_q[DW-2:0], step_q};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DW - 1)) begin
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (dzp_q) begin
          q_d  = '1;
          r_d  = '1;
          dz_d = 1'b1;
        end else begin
          q_d  = q_fin;
          r_d  = r_fin;
          dz_d = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      p_q     <= '0;
      b_q     <= '0;
      dzp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      p_q     <= p_d;
      b_q     <= b_d;
      dzp_q   <= dzp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

`ifdef DIV_SIGNED_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign Q    = q_q;
  assign R    = r_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed cases from the test plan plus random operands
// checked against an arithmetic reference model.
module tb_seq_div;
  import div_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [7:0]  B;
  logic        busy;
  logic        done;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        dz;

  int checks;
  int errors;

  logic [15:0] exp_q;
  logic [7:0]  exp_r;
  logic        exp_z;
  int          exp_lat;

  seq_div #(
    .DW(16),
    .VW(8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .Q    (Q),
    .R    (R),
    .dz   (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain arithmetic on the operands.
  task automatic model(input logic [15:0] a, input logic [7:0] b,
                       output logic [15:0] q, output logic [7:0] r, output logic z);
`ifdef DIV_SIGNED_EN
    int sa;
    int sb;
`endif
    if (b == 8'd0) begin
      q = DzQuot;
      r = DzRem;
      z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = 16'(sa / sb);
      r  = 8'(sa % sb);
`else
      q  = a / {8'd0, b};
      r  = 8'(a % {8'd0, b});
`endif
      z = 1'b0;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic do_start(input logic [15:0] a, input logic [7:0] b);
    A     = a;
    B     = b;
    start = 1'b1;
    model(a, b, exp_q, exp_r, exp_z);
    exp_lat = (b == 8'd0) ? 1 : 17;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done; 'elapsed' is edges already passed since the accepting edge.
  task automatic wait_done(input string tag, input int elapsed);
    int n;
    bit dropped;
    n       = elapsed;
    dropped = 1'b0;
    if (!busy) dropped = 1'b1;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy) dropped = 1'b1;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " busy held"}, {31'd0, dropped}, 32'd0);
    check({tag, " Q"}, {16'd0, Q}, {16'd0, exp_q});
    check({tag, " R"}, {24'd0, R}, {24'd0, exp_r});
    check({tag, " dz"}, {31'd0, dz}, {31'd0, exp_z});
  endtask

  task automatic tail(input string tag);
    @(posedge clk);
    #1;
    check({tag, " busy fall"}, {31'd0, busy}, 32'd0);
    check({tag, " done pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    bit          saw_done;
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    start  = 1'b0;
    A      = '0;
    B      = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset Q", {16'd0, Q}, 32'd0);
    check("reset R", {24'd0, R}, 32'd0);
    check("reset dz", {31'd0, dz}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1000 / 7 with busy for exactly 18 cycles.
    do_start(16'd1000, 8'd7);
    wait_done("1000/7", 0);
    tail("1000/7");
    repeat (3) @(posedge clk);
    #1;
    check("hold Q", {16'd0, Q}, {16'd0, exp_q});

    // Back-to-back at the earliest legal edge.
    do_start(16'hFFFF, 8'hFF);
    wait_done("ffff/ff", 0);
    do_start(16'hAA55, 8'h55);
    check("b2b busy", {31'd0, busy}, 32'd1);
    check("b2b done low", {31'd0, done}, 32'd0);
    wait_done("aa55/55", 0);
    tail("aa55/55");

    // Divide by zero, then a normal division clears dz.
    do_start(16'h1234, 8'd0);
    wait_done("div0", 0);
    tail("div0");
    do_start(16'd100, 8'd3);
    wait_done("after div0", 0);
    tail("after div0");

    // Start while busy is ignored.
    do_start(16'd1000, 8'd7);
    repeat (4) @(posedge clk);
    #1;
    A     = 16'd5;
    B     = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore start", 5);
    tail("ignore start");

    // Reset mid-run aborts without presenting a result.
    do_start(16'd1000, 8'd7);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort Q", {16'd0, Q}, 32'd0);
    check("abort R", {24'd0, R}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b1;
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("abort no done", {31'd0, saw_done}, 32'd0);
    do_start(16'd200, 8'd9);
    wait_done("200/9", 0);
    tail("200/9");

    // Signed-sensitive operand patterns; the model follows the build option.
    do_start(16'hFC18, 8'd7);
    wait_done("fc18/7", 0);
    tail("fc18/7");
    do_start(16'h8000, 8'hFF);
    wait_done("8000/ff", 0);
    tail("8000/ff");

    // Random operands, alternately back-to-back.
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      do_start(ra, rb);
      wait_done("random", 0);
      if (i % 2 == 1) tail("random");
    end
    tail("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_div.md
# seq_div

Sequential restoring divider: the inverse of the team's 8×8 multiplier. Takes a 16-bit dividend and an 8-bit divisor, produces a 16-bit quotient and an 8-bit remainder one bit per clock under a start/done handshake. It sits beside the multiplier in the arithmetic datapath, and its operand and result widths mirror the multiplier's 8-bit inputs and 16-bit product.

## Interface
Parameters:
- DW, 16, dividend and quotient width
- VW, 8, divisor and remainder width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  request a division; sampled only in IDLE
- A  in  DW  dividend
- B  in  VW  divisor
- busy  out  1  high from the accepting edge until DONE is left
- done  out  1  one-cycle pulse; Q, R and dz are valid
- Q  out  DW  quotient, held until the next completion
- R  out  VW  remainder, held until the next completion
- dz  out  1  divide-by-zero flag, held with Q and R

## Operation
- States and transitions:
  - IDLE: start=1 latches A and B. If B==0, go to DONE; otherwise go to RUN with count=0 and partial remainder P=0 (VW+1 bits).
  - RUN: each cycle, P = {P, next dividend MSB}. If P >= B, then P -= B and the quotient bit is 1; otherwise the bit is 0. count increments; after the DW-th iteration, go to DONE.
  - DONE: load Q, R and dz, pulse done, then return to IDLE. A start in the DONE cycle is ignored.
- start while busy is ignored. Operands are not re-sampled, and an in-flight operation is never disturbed.
- Divide by zero: Q = all ones (0xFFFF), R = all ones (0xFF), dz=1.
- Normal result: A = Q*B + R, with 0 <= R < B and dz=0.
- Reset:
  - rst low at any time, including mid-RUN, forces IDLE immediately.
  - On reset: busy=0, done=0, Q=0, R=0, dz=0, internal state cleared.
  - The aborted result is never presented.
- Internal width: P needs VW+1 bits so the compare does not overflow when B >= 0x80.

## Timing
- start sampled high at edge 0 with B != 0:
  - busy high after edge 0.
  - RUN occupies edges 1..16.
  - done high for the cycle after edge 17, with Q, R and dz updated at edge 17.
  - busy falls at edge 18.
- B == 0: done and dz high for the cycle after edge 1; busy falls at edge 2.
- Throughput: one division per 18 cycles. A new start is accepted at edge 18 at the earliest.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- DIV_SIGNED_EN defined:
  - A and B are two's complement; magnitudes are taken at load and signs are applied entering DONE.
  - Q truncates toward zero; R takes the sign of A.
  - -32768 / -1 wraps to Q=0x8000, R=0, dz=0.
  - Divide-by-zero results are unchanged.
- DIV_SIGNED_EN undefined: fully unsigned, and no sign logic is compiled in.

## Structure
- Package div_pkg holds:
  - DW and VW defaults
  - the state enum (IDLE, RUN, DONE)
  - iteration-count width, clog2(DW+1)
  - divide-by-zero result constants
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: P, incoming bit, B.
  - Outputs: next P, quotient bit.
  - It is instantiated once.

## Test plan
- A=1000, B=7, start pulse → done after edge 17: Q=142, R=6, dz=0; busy high for exactly 18 cycles.
- A=0xFFFF, B=0xFF → Q=0x0101, R=0. A=0xAA55, B=0x55 → Q=0x0201, R=0. Back-to-back starts are issued at the earliest legal edge.
- A=0x1234, B=0 → done after edge 1 with Q=0xFFFF, R=0xFF, dz=1; the next division clears dz.
- Start 1000/7, then pulse start with A=5, B=1 at edge 5 → ignored; the result is still Q=142, R=6.
- Start 1000/7, assert rst at edge 8 → busy=0, Q=0, R=0 at once, and no done pulse. After release, 200/9 gives Q=22, R=2.
- DIV_SIGNED_EN: A=-1000 (0xFC18), B=7 → Q=0xFF72 (-142), R=0xFA (-6). A=0x8000, B=0xFF → Q=0x8000, R=0.
